// File: rtl/audio_sample_fifo.sv
// rtl/audio_sample_fifo.sv - stereo sample FIFO between mixer and I2S, popped on divided LRCLK rises
module audio_sample_fifo #(
  parameter int WIDTH         = 24,
  parameter int DEPTH         = 16,
  parameter int DIV           = 1,
  parameter bit UNDERRUN_HOLD = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    lrclk,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_l,
  input  logic [WIDTH-1:0]        in_r,
  output logic [WIDTH-1:0]        out_l,
  output logic [WIDTH-1:0]        out_r,
  output logic                    sample_tick,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    underrun,
  output logic [15:0]             underrun_count,
  input  logic                    clr_stats
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      cnt;
  logic               s1, s2, s3;
  logic               rise, pop, push, empty;

  assign rise     = s2 & ~s3;
  assign pop      = rise && (cnt == CNT_LAST);
  assign empty    = (level == '0);
  assign in_ready = (level != FULL_LEVEL);
  assign push     = in_valid & in_ready;

  // Bring LRCLK into the clk domain; preset high so lrclk already high at reset release is not an edge
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= lrclk;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Count LRCLK rises so that only every DIV-th rise produces a pop
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (rise) begin
      if (cnt == CNT_LAST) cnt <= '0;
      else                 cnt <= cnt + CW'(1);
    end
  end

  // Sample storage; no reset needed because level gates every read
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_l, in_r};
  end

  // Pointers, fill level and the registered output pair
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      out_l       <= '0;
      out_r       <= '0;
      sample_tick <= 1'b0;
    end else begin
      sample_tick <= pop;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        if (!empty) begin
          {out_l, out_r} <= mem[rd_ptr];
          rd_ptr         <= rd_ptr + AW'(1);
        end else if (!UNDERRUN_HOLD) begin
          out_l <= '0;
          out_r <= '0;
        end
      end
      if (push && !(pop && !empty))      level <= level + LW'(1);
      else if (!push && (pop && !empty)) level <= level - LW'(1);
    end
  end

  // Underrun statistics; a clear wins over an increment in the same cycle
  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      underrun       <= 1'b0;
      underrun_count <= '0;
    end else if (pop && empty) begin
      underrun <= 1'b1;
      if (underrun_count != 16'hFFFF) underrun_count <= underrun_count + 16'd1;
    end
  end

endmodule

// File: doc/audio_sample_fifo.md
Name: audio_sample_fifo

Overview:
Parametrised stereo sample buffer between the mixer (io_outL/io_outR producer) and the I2S transmitter.
- Accepts samples through a valid/ready handshake.
- Synchronises LRCLK and pops one stereo sample every DIV LRCLK rising edges. This generalises the fixed divide-by-8 48 kHz pulse logic.
- Reports fill level and underruns.
- Replaces the direct mixer-to-i2s_ctl wiring in top.

Parameters:
- WIDTH, 24, bits per channel sample.
- DEPTH, 16, FIFO entries (stereo pairs); power of two, >=2.
- DIV, 1, LRCLK rising edges per pop; >=1.
- UNDERRUN_HOLD, 1, 1 = repeat last sample on underrun; 0 = output zero.

Ports:
- clk, input, 1, system clock (100 MHz domain); single clock domain.
- rst, input, 1, synchronous active-high reset.
- lrclk, input, 1, I2S LRCLK; treated as asynchronous.
- in_valid, input, 1, producer has a sample.
- in_ready, output, 1, FIFO can accept a sample.
- in_l, input, WIDTH, left sample.
- in_r, input, WIDTH, right sample.
- out_l, output, WIDTH, current left sample to I2S.
- out_r, output, WIDTH, current right sample to I2S.
- sample_tick, output, 1, one-cycle pulse when out_l/out_r update.
- level, output, $clog2(DEPTH)+1, entries stored.
- underrun, output, 1, sticky flag: a pop found the FIFO empty.
- underrun_count, output, 16, saturating underrun counter.
- clr_stats, input, 1, clears underrun and underrun_count.

Behaviour:
- Reset (rst=1 at a clk edge):
  - Pointers and level go to 0.
  - out_l, out_r go to 0; sample_tick=0; underrun=0; underrun_count=0.
  - Divider count goes to 0.
  - LRCLK sync flops s1, s2, s3 go to 1, so lrclk already high at reset release gives no spurious edge.
  - Reset mid-operation discards all stored data.
- LRCLK sync: s1<=lrclk, s2<=s1, s3<=s2. rise = s2 & ~s3.
- Divider, on rise:
  - if cnt==DIV-1: cnt<=0 and raise pop.
  - else: cnt<=cnt+1.
  - DIV=1 pops on every rise.
- Pop (registered, acts on the edge after rise):
  - sample_tick=1 for exactly one cycle.
  - Not empty: out_l/out_r <= head entry; read pointer +1 (wraps mod DEPTH).
  - Empty: out holds its value (UNDERRUN_HOLD=1) or goes to 0 (UNDERRUN_HOLD=0); underrun<=1; underrun_count +1, saturating at 16'hFFFF.
- Latency: sample_tick is high in the cycle after the 3rd clk edge counted from the first edge that samples lrclk=1.
- Push: in_ready = (level != DEPTH), combinational from registered level. The write occurs when in_valid & in_ready at a clk edge; write pointer +1, wraps mod DEPTH.
- Simultaneous push and pop:
  - Both occur; level unchanged.
  - When empty, the pop sees empty (underrun); there is no bypass, and the pushed sample is stored.
  - When full, in_ready=0, so only the pop occurs.
- level: +1 on push only, -1 on pop-with-data only, otherwise unchanged. Never exceeds DEPTH and never goes below 0.
- clr_stats: clears underrun and underrun_count on the next edge. It takes priority over a same-cycle increment.
- in_l/in_r are sampled only on an accepted push. Values offered while in_ready=0 are ignored.

Test Plan:
- Reset, DIV=1: push 0x000001/0x800001, then 0x000002/0x800002.
  - Two lrclk rises → two sample_tick pulses, each 3 edges after lrclk is sampled high.
  - out_l shows 0x000001 then 0x000002; level goes 2→1→0.
- DIV=8: 16 lrclk rises → exactly 2 sample_tick pulses, on the 8th and 16th rise.
- Fill 16 entries → in_ready=0, level=16.
  - A 17th in_valid is not stored.
  - One pop → in_ready=1 next cycle.
  - Push 0x00ABCD → it is read back after 16 pops (wrap verified).
- Empty FIFO, UNDERRUN_HOLD=1, last out_l=0x123456: 3 pops → out_l stays 0x123456, underrun=1, underrun_count=3. Assert clr_stats → both become 0.
- UNDERRUN_HOLD=0, empty pop → out_l=out_r=0. Push and pop in the same cycle while empty → underrun_count=1, level=1.
- lrclk held high through reset release → no sample_tick until lrclk goes low then high. Reset asserted with level=5 → level=0, out_l=0 on the next edge.
